tt_um_serial_subtractor: RTL and testbench



---
 rtl/tt_um_serial_subtractor.sv | 82 ++++++++
 tb/tb_tt_um_serial_subtractor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial subtractor tile: consumes operands A and B LSB first and assembles
// A - B (mod 256) in a right-shifting register. The borrow ripples through a
// single flop. Status and the bit count are reported on the bidirectional pins.
module tt_um_serial_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned Width = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [Width-1:0] diff_q;
  logic             borrow_q;
  logic [3:0]       cnt_q;
  logic             ovf_q;

  logic a_bit, b_bit, bit_valid, start;
  logic diff_bit, borrow_d;

  assign a_bit     = ui_in[0];
  assign b_bit     = ui_in[1];
  assign bit_valid = ui_in[2];
  assign start     = ui_in[3];

  // Pins with no function; folded here so they are visibly consumed.
  logic unused;
  assign unused = ^{uio_in, ui_in[7:4]};

  // One full-subtractor slice: difference bit and the borrow into the next bit.
  always_comb begin
    diff_bit = a_bit ^ b_bit ^ borrow_q;
    borrow_d = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
  end

  // Control FSM and datapath; start beats bit_valid and restarts from any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (ena) begin
      if (start) begin
        state_q  <= StShift;
        diff_q   <= '0;
        borrow_q <= 1'b0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
      end else if (state_q == StShift && bit_valid) begin
        diff_q   <= {diff_bit, diff_q[Width-1:1]};
        borrow_q <= borrow_d;
        cnt_q    <= cnt_q + 4'd1;
        if (cnt_q == 4'(Width - 1)) begin
          state_q <= StDone;
          // Signed overflow: operand signs differ and the result sign differs from A.
          ovf_q   <= (a_bit != b_bit) && (diff_bit != a_bit);
        end
      end
    end
  end

  // Outputs are decoded straight from registers; no path from ui_in.
  always_comb begin
    uo_out  = diff_q;
    uio_out = {cnt_q, ovf_q, (state_q == StShift), borrow_q, (state_q == StDone)};
    uio_oe  = 8'hFF;
  end

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Self-checking bench for the serial subtractor: an arithmetic model of the
// received operand prefixes is compared with the DUT every cycle, and directed
// scenarios pin specific results with literal expectations.
module tb_tt_um_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_serial_subtractor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase (0 idle, 1 shifting, 2 done), bits received, operand prefixes.
  int  m_phase = 0;
  int  m_k     = 0;
  int  m_a     = 0;
  int  m_b     = 0;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_a = 0; m_b = 0;
      m_valid = 1'b1;
    end else if (ena) begin
      if (ui_in[3]) begin
        m_phase = 1; m_k = 0; m_a = 0; m_b = 0;
      end else if (m_phase == 1 && ui_in[2]) begin
        m_a = m_a | (int'(ui_in[0]) << m_k);
        m_b = m_b | (int'(ui_in[1]) << m_k);
        m_k++;
        if (m_k == 8) m_phase = 2;
      end
    end
  end

  function automatic int exp_uo();
    int mask;
    if (m_k == 0) return 0;
    mask = (1 << m_k) - 1;
    return (((m_a - m_b) & mask) << (8 - m_k)) & 255;
  endfunction

  function automatic int exp_uio();
    int sa, sb, r, ovf, brw;
    ovf = 0;
    if (m_phase == 2) begin
      sa  = (m_a >= 128) ? m_a - 256 : m_a;
      sb  = (m_b >= 128) ? m_b - 256 : m_b;
      r   = sa - sb;
      ovf = (r > 127 || r < -128) ? 1 : 0;
    end
    brw = (m_a < m_b) ? 1 : 0;
    return (m_k << 4) | (ovf << 3) | (((m_phase == 1) ? 1 : 0) << 2) | (brw << 1)
         | ((m_phase == 2) ? 1 : 0);
  endfunction

  // Every-cycle comparison against the model once a reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model uo_out", int'(uo_out), exp_uo());
      check("model uio_out", int'(uio_out), exp_uio());
      check("uio_oe", int'(uio_oe), 8'hFF);
    end
  end

  task automatic tick(input bit st, input bit v, input bit a, input bit b);
    ui_in = {4'h0, st, v, b, a};
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int gap_pos,
                        input int gap_len);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("busy after start", int'(uio_out[2]), 1);
    check("done after start", int'(uio_out[0]), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_pos) begin
        for (int g = 0; g < gap_len; g++) begin
          tick(1'b0, 1'b0, a[i], b[i]);
          check("busy in gap", int'(uio_out[2]), 1);
        end
      end
      tick(1'b0, 1'b1, a[i], b[i]);
    end
  endtask

  logic [7:0] ta, tb;

  initial begin
    ui_in  = 8'h00;
    uio_in = 8'hA5;
    ena    = 1'b1;
    rst_n  = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset uo_out", int'(uo_out), 8'h00);
    check("reset uio_out", int'(uio_out), 8'h00);
    check("reset uio_oe", int'(uio_oe), 8'hFF);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("idle uo_out", int'(uo_out), 8'h00);
    check("idle uio_out", int'(uio_out), 8'h00);

    // 5 - 3 back-to-back
    run_op(8'h05, 8'h03, -1, 0);
    check("5-3 diff", int'(uo_out), 8'h02);
    check("5-3 done", int'(uio_out[0]), 1);
    check("5-3 borrow", int'(uio_out[1]), 0);
    check("5-3 ovf", int'(uio_out[3]), 0);
    check("5-3 count", int'(uio_out[7:4]), 8);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    check("done holds diff", int'(uo_out), 8'h02);

    // 3 - 5 with a 3-cycle gap between bits 2 and 3
    run_op(8'h03, 8'h05, 3, 3);
    check("3-5 diff", int'(uo_out), 8'hFE);
    check("3-5 borrow", int'(uio_out[1]), 1);
    check("3-5 ovf", int'(uio_out[3]), 0);

    // 0x80 - 0x01 then 0 - 0 started the cycle done is seen
    run_op(8'h80, 8'h01, -1, 0);
    check("80-01 diff", int'(uo_out), 8'h7F);
    check("80-01 borrow", int'(uio_out[1]), 0);
    check("80-01 ovf", int'(uio_out[3]), 1);
    run_op(8'h00, 8'h00, -1, 0);
    check("00-00 diff", int'(uo_out), 8'h00);
    check("00-00 borrow", int'(uio_out[1]), 0);
    check("00-00 done", int'(uio_out[0]), 1);

    // Abort by start after 4 bits of 0xFF - 0x00
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("partial FF count", int'(uio_out[7:4]), 4);
    run_op(8'h10, 8'h20, -1, 0);
    check("10-20 diff", int'(uo_out), 8'hF0);
    check("10-20 borrow", int'(uio_out[1]), 1);

    // Reset mid-shift
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    check("abort rst uo_out", int'(uo_out), 8'h00);
    check("abort rst uio_out", int'(uio_out), 8'h00);

    // ena low mid-operation: 0x64 - 0x1E
    ta = 8'h64;
    tb = 8'h1E;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, ta[i], tb[i]);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, ta[3], tb[3]);
    check("frozen uo_out", int'(uo_out), 8'hC0);
    check("frozen count", int'(uio_out[7:4]), 3);
    check("frozen borrow", int'(uio_out[1]), 1);
    ena = 1'b1;
    for (int i = 3; i < 8; i++) tick(1'b0, 1'b1, ta[i], tb[i]);
    check("64-1E diff", int'(uo_out), 8'h46);
    check("64-1E done", int'(uio_out[0]), 1);
    check("64-1E borrow", int'(uio_out[1]), 0);

    tick(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
